matmul_sequencer: RTL and testbench

Parametrised control sequencer for the matrix multiplier datapath: computes C = A·B for A of ROWS×INNER and B of INNER×COLS, one output element at a time. Generates operand load, multiply-accumulate enable, accumulator clear and element indices. Presents each finished element through a valid/ready store handshake and signals completion with a one-cycle `done` pulse. Successor to the fixed 8-entry controller: dimensions are parameters, per-element accumulation, store back-pressure and abort are added.

---
 rtl/matmul_sequencer_pkg.sv | 24 ++
 rtl/matmul_sequencer_if.sv | 29 ++
 rtl/matmul_sequencer_index_counter.sv | 56 +++++
 rtl/matmul_sequencer.sv | 119 +++++++++++
 tb/tb_matmul_sequencer.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/matmul_sequencer_pkg.sv
// Shared types and defaults for the matrix-multiply control sequencer.
package matmul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MAC   = 3'd2,
        ST_STORE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int DEF_ROWS  = 2;
    localparam int DEF_COLS  = 2;
    localparam int DEF_INNER = 8;
    localparam int DEF_IDX_W = 4;

    // Largest of the three dimensions; the index width must cover it.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/matmul_sequencer_if.sv
// Control/store handshake bundle between the sequencer and its user.
interface matmul_sequencer_if #(
    parameter int IDX_W = matmul_pkg::DEF_IDX_W
);
    logic             start;
    logic             abort;
    logic             store_ready;
    logic             busy;
    logic             load_matrix;
    logic             mac_en;
    logic             acc_clear;
    logic [IDX_W-1:0] row_idx;
    logic [IDX_W-1:0] col_idx;
    logic [IDX_W-1:0] k_idx;
    logic             store_valid;
    logic             done;

    modport master (
        output start, abort, store_ready,
        input  busy, load_matrix, mac_en, acc_clear,
               row_idx, col_idx, k_idx, store_valid, done
    );

    modport slave (
        input  start, abort, store_ready,
        output busy, load_matrix, mac_en, acc_clear,
               row_idx, col_idx, k_idx, store_valid, done
    );
endinterface

// File: rtl/matmul_sequencer_index_counter.sv
// Nested k / col / row counter walking C in row-major order.
module matmul_index_counter
    import matmul_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int COLS  = DEF_COLS,
    parameter int INNER = DEF_INNER,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             k_step,
    input  logic             advance,
    output logic [IDX_W-1:0] row_idx,
    output logic [IDX_W-1:0] col_idx,
    output logic [IDX_W-1:0] k_idx,
    output logic             last_k,
    output logic             last_element
);

    localparam logic [IDX_W-1:0] K_LAST   = IDX_W'(INNER - 1);
    localparam logic [IDX_W-1:0] COL_LAST = IDX_W'(COLS - 1);
    localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(ROWS - 1);
    localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

    // clr wins; advance moves to the next element, k_step walks the inner index
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row_idx <= '0;
            col_idx <= '0;
            k_idx   <= '0;
        end else if (clr) begin
            row_idx <= '0;
            col_idx <= '0;
            k_idx   <= '0;
        end else if (advance) begin
            k_idx <= '0;
            if (col_idx == COL_LAST) begin
                col_idx <= '0;
                row_idx <= row_idx + ONE;
            end else begin
                col_idx <= col_idx + ONE;
            end
        end else if (k_step) begin
            k_idx <= k_idx + ONE;
        end
    end

    // terminal-count flags consumed by the FSM
    always_comb begin
        last_k       = (k_idx == K_LAST);
        last_element = (row_idx == ROW_LAST) && (col_idx == COL_LAST);
    end

endmodule

// File: rtl/matmul_sequencer.sv
// Control sequencer for C = A*B, one output element at a time.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int COLS  = DEF_COLS,
    parameter int INNER = DEF_INNER,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic               clock,
    input  logic               reset,
    matmul_sequencer_if.slave  bus
);

    generate
        if (ROWS < 1 || COLS < 1 || INNER < 1) begin : g_bad_dim
            $error("matmul_sequencer: all dimensions must be at least 1");
        end
        if ((2 ** IDX_W) < max3(ROWS, COLS, INNER)) begin : g_bad_idx_w
            $error("matmul_sequencer: IDX_W too narrow for the dimensions");
        end
    endgenerate

    state_t           state, state_nx;
    logic             cnt_clr, k_step, advance;
    logic             last_k, last_element;
    logic [IDX_W-1:0] row_idx, col_idx, k_idx;

    matmul_index_counter #(
        .ROWS (ROWS),
        .COLS (COLS),
        .INNER(INNER),
        .IDX_W(IDX_W)
    ) u_idx (
        .clock       (clock),
        .reset       (reset),
        .clr         (cnt_clr),
        .k_step      (k_step),
        .advance     (advance),
        .row_idx     (row_idx),
        .col_idx     (col_idx),
        .k_idx       (k_idx),
        .last_k      (last_k),
        .last_element(last_element)
    );

    // state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // next state and counter control; abort overrides everything else
    always_comb begin
        state_nx = state;
        cnt_clr  = 1'b0;
        k_step   = 1'b0;
        advance  = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (bus.start && !bus.abort) state_nx = ST_LOAD;
            end
            ST_LOAD: begin
                if (bus.abort) begin
                    state_nx = ST_IDLE;
                    cnt_clr  = 1'b1;
                end else begin
                    state_nx = ST_MAC;
                end
            end
            ST_MAC: begin
                if (bus.abort) begin
                    state_nx = ST_IDLE;
                    cnt_clr  = 1'b1;
                end else if (last_k) begin
                    state_nx = ST_STORE;
                end else begin
                    k_step = 1'b1;
                end
            end
            ST_STORE: begin
                if (bus.abort) begin
                    state_nx = ST_IDLE;
                    cnt_clr  = 1'b1;
                end else if (bus.store_ready) begin
                    if (last_element) begin
                        state_nx = ST_DONE;
                    end else begin
                        state_nx = ST_MAC;
                        advance  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
                cnt_clr  = 1'b1;
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_clr  = 1'b1;
            end
        endcase
    end

    // Moore output decode from registered state and counters
    always_comb begin
        bus.busy        = (state != ST_IDLE);
        bus.load_matrix = (state == ST_LOAD);
        bus.mac_en      = (state == ST_MAC);
        bus.acc_clear   = (state == ST_MAC) && (k_idx == '0);
        bus.store_valid = (state == ST_STORE);
        bus.done        = (state == ST_DONE);
        bus.row_idx     = row_idx;
        bus.col_idx     = col_idx;
        bus.k_idx       = k_idx;
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed and randomized bench for matmul_sequencer (2x2x8 and 1x1x1).
module tb_matmul_sequencer;
    import matmul_pkg::*;

    localparam int R = 2;
    localparam int C = 2;
    localparam int I = 8;
    localparam int W = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc_ctr = 0;
    int   done_cnt = 0;
    int   done_at = 0;
    int   t0 = 0;

    always #5 clock = ~clock;

    matmul_sequencer_if #(.IDX_W(W)) bus0 ();
    matmul_sequencer_if #(.IDX_W(2)) bus1 ();

    matmul_sequencer #(.ROWS(R), .COLS(C), .INNER(I), .IDX_W(W)) dut0 (
        .clock(clock), .reset(reset), .bus(bus0.slave)
    );
    matmul_sequencer #(.ROWS(1), .COLS(1), .INNER(1), .IDX_W(2)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1.slave)
    );

    always @(posedge clock) cyc_ctr++;
    always @(negedge clock) if (bus0.done === 1'b1) begin
        done_cnt++;
        done_at = cyc_ctr;
    end

    function automatic logic [17:0] ev0(input bit b, input bit ld, input bit m, input bit cl,
                                        input bit sv, input bit dn, input int r, input int c, input int k);
        return {b, ld, m, cl, sv, dn, 4'(r), 4'(c), 4'(k)};
    endfunction

    function automatic logic [17:0] obs0();
        return {bus0.busy, bus0.load_matrix, bus0.mac_en, bus0.acc_clear, bus0.store_valid,
                bus0.done, bus0.row_idx, bus0.col_idx, bus0.k_idx};
    endfunction

    function automatic logic [11:0] obs1();
        return {bus1.busy, bus1.load_matrix, bus1.mac_en, bus1.acc_clear, bus1.store_valid,
                bus1.done, bus1.row_idx, bus1.col_idx, bus1.k_idx};
    endfunction

    task automatic chk0(input string tag, input logic [17:0] exp, input logic [17:0] mask = '1);
        checks++;
        assert ((obs0() & mask) === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs0() & mask, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic [11:0] exp, input logic [11:0] mask = '1);
        checks++;
        assert ((obs1() & mask) === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs1() & mask, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference walk of one multiply: row-major elements, INNER MAC cycles each,
    // then STORE until the bench offers store_ready.
    task automatic run0(input string tag, input int stall_el, input int stall_n, input bit rnd_sr,
                        input bit rnd_start, input int abort_el, input int abort_k);
        int  stalls, e, n, dn0;
        bit  sr;
        stalls = 0;
        dn0 = done_cnt;
        bus0.abort = 1'b0;
        bus0.store_ready = 1'b1;
        bus0.start = 1'b1;
        tick();
        t0 = cyc_ctr;
        bus0.start = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
        chk0({tag, " load"}, ev0(1, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                e = r * C + c;
                for (int k = 0; k < I; k++) begin
                    tick();
                    chk0({tag, " mac"}, ev0(1, 0, 1, k == 0, 0, 0, r, c, k));
                    if (rnd_start) bus0.start = 1'($urandom_range(0, 1));
                    if (e == abort_el && k == abort_k) begin
                        bus0.abort = 1'b1;
                        tick();
                        bus0.abort = 1'b0;
                        bus0.start = 1'b0;
                        chk0({tag, " abort idle"}, '0);
                        tick();
                        chk0({tag, " abort stays idle"}, '0);
                        chk_int({tag, " abort no done"}, done_cnt, dn0);
                        return;
                    end
                end
                n = 0;
                sr = 1'b0;
                while (!sr) begin
                    tick();
                    chk0({tag, " store"}, ev0(1, 0, 0, 0, 1, 0, r, c, I - 1));
                    if (rnd_start) bus0.start = 1'($urandom_range(0, 1));
                    if (e == stall_el) sr = (n >= stall_n);
                    else if (rnd_sr)   sr = (n >= 5) ? 1'b1 : 1'($urandom_range(0, 1));
                    else               sr = 1'b1;
                    bus0.store_ready = sr;
                    if (!sr) begin
                        n++;
                        stalls++;
                    end
                end
            end
        end
        tick();
        bus0.start = 1'b0;
        chk0({tag, " done"}, ev0(1, 0, 0, 0, 0, 1, 0, 0, 0), 18'h3F000);
        tick();
        chk0({tag, " idle after"}, '0);
        chk_int({tag, " done cycle"}, done_at - t0 + 1, 2 + R * C * (I + 1) + stalls);
        chk_int({tag, " one done"}, done_cnt - dn0, 1);
    endtask

    initial begin
        bus0.start = 1'b0; bus0.abort = 1'b0; bus0.store_ready = 1'b0;
        bus1.start = 1'b0; bus1.abort = 1'b0; bus1.store_ready = 1'b1;
        #1;
        chk0("reset dut0", '0);
        chk1("reset dut1", '0);
        tick();
        @(negedge clock);
        reset = 1'b1;
        tick();
        chk0("idle after reset", '0);

        // start together with abort must not launch
        bus0.start = 1'b1;
        bus0.abort = 1'b1;
        tick();
        bus0.start = 1'b0;
        bus0.abort = 1'b0;
        chk0("start+abort idle", '0);
        tick();
        chk0("start+abort still idle", '0);

        run0("base", -1, 0, 1'b0, 1'b0, -1, 0);
        run0("stall01", 1, 3, 1'b0, 1'b0, -1, 0);
        run0("abort10", -1, 0, 1'b0, 1'b0, 2, 4);
        run0("after abort", -1, 0, 1'b0, 1'b0, -1, 0);

        // asynchronous reset in the middle of the first STORE
        bus0.store_ready = 1'b0;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        repeat (I + 1) tick();
        chk0("pre-reset store", ev0(1, 0, 0, 0, 1, 0, 0, 0, I - 1));
        #2;
        reset = 1'b0;
        #1;
        chk0("async reset dut0", '0);
        chk1("async reset dut1", '0);
        tick();
        chk0("held in reset", '0);
        @(negedge clock);
        reset = 1'b1;
        bus0.store_ready = 1'b1;
        repeat (3) begin
            tick();
            chk0("needs start", '0);
        end

        repeat (4) run0("rnd", int'($urandom_range(0, R * C - 1)), int'($urandom_range(0, 4)),
                        1'b1, 1'b1, -1, 0);

        // 1x1x1 instance
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        chk1("tiny load", 12'b110000_00_00_00);
        tick();
        chk1("tiny mac", 12'b101100_00_00_00);
        tick();
        chk1("tiny store", 12'b100010_00_00_00);
        tick();
        chk1("tiny done", 12'b100001_00_00_00, 12'hFC0);
        tick();
        chk1("tiny idle", '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
